// File: rtl/wb_regfile.sv
// Writeback-stage register file: forms the write address and data (with load extension),
// holds the 32x32 GPRs, and serves two combinational read ports with write-through bypass.
module wb_regfile #(
  parameter logic [31:0] RESET_SP = 32'h0000_2ffc,
  parameter logic [31:0] RESET_GP = 32'h0000_1800
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] ins_W,
  input  logic [31:0] ALUout_W,
  input  logic [31:0] RData_W,
  input  logic [31:0] PC8_W,
  input  logic        MemtoReg,
  input  logic        RegDst,
  input  logic        RegWrite,
  input  logic        jal_W,
  input  logic [2:0]  RM_extOp,
  input  logic [4:0]  A1,
  input  logic [4:0]  A2,
  output logic [31:0] RD1,
  output logic [31:0] RD2,
  output logic        WE_out,
  output logic [4:0]  WA_out,
  output logic [31:0] WD_out
);

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;

  logic [XLEN-1:0] r_regs [NREGS];
  logic            w_jalr;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_load;
  logic            w_unused;

  // Fields of ins_W not needed for address/data selection.
  assign w_unused = &{1'b0, ins_W[25:21], ins_W[10:6]};

  assign w_jalr = (ins_W[31:26] == 6'd0) && (ins_W[5:0] == 6'b001001);

  // Little-endian byte/halfword pick from the aligned memory word.
  always_comb begin
    w_byte = RData_W[7:0];
    case (ALUout_W[1:0])
      2'd0: w_byte = RData_W[7:0];
      2'd1: w_byte = RData_W[15:8];
      2'd2: w_byte = RData_W[23:16];
      2'd3: w_byte = RData_W[31:24];
      default: w_byte = RData_W[7:0];
    endcase
    w_half = ALUout_W[1] ? RData_W[31:16] : RData_W[15:0];
  end

  always_comb begin
    w_load = RData_W;
    case (RM_extOp)
      3'd1: w_load = {24'd0, w_byte};
      3'd2: w_load = {{24{w_byte[7]}}, w_byte};
      3'd3: w_load = {16'd0, w_half};
      3'd4: w_load = {{16{w_half[15]}}, w_half};
      default: w_load = RData_W;
    endcase
  end

  // Committed write: jal forces $31; link data wins over load and ALU data.
  always_comb begin
    WA_out = jal_W ? 5'd31 : (RegDst ? ins_W[15:11] : ins_W[20:16]);
    if (jal_W || w_jalr) begin
      WD_out = PC8_W;
    end else if (MemtoReg) begin
      WD_out = w_load;
    end else begin
      WD_out = ALUout_W;
    end
    WE_out = RegWrite && (WA_out != 5'd0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < int'(NREGS); i++) begin
        if (i == 28) begin
          r_regs[i] <= RESET_GP;
        end else if (i == 29) begin
          r_regs[i] <= RESET_SP;
        end else begin
          r_regs[i] <= '0;
        end
      end
    end else if (WE_out) begin
      r_regs[WA_out] <= WD_out;
    end
  end

  // Read ports: $0 reads zero, a same-cycle write to the read address bypasses storage.
  always_comb begin
    if (A1 == 5'd0) begin
      RD1 = '0;
    end else if (WE_out && (A1 == WA_out)) begin
      RD1 = WD_out;
    end else begin
      RD1 = r_regs[A1];
    end
    if (A2 == 5'd0) begin
      RD2 = '0;
    end else if (WE_out && (A2 == WA_out)) begin
      RD2 = WD_out;
    end else begin
      RD2 = r_regs[A2];
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Self-checking bench for wb_regfile: directed scenarios plus randomized traffic
// compared against an array-based register model.
module tb_wb_regfile;

  logic        clk;
  logic        reset_n;
  logic [31:0] ins_W, ALUout_W, RData_W, PC8_W;
  logic        MemtoReg, RegDst, RegWrite, jal_W;
  logic [2:0]  RM_extOp;
  logic [4:0]  A1, A2;
  logic [31:0] RD1, RD2;
  logic        WE_out;
  logic [4:0]  WA_out;
  logic [31:0] WD_out;

  int unsigned vectors;
  int unsigned miscompares;
  logic [31:0] model [32];

  wb_regfile dut (
    .clk(clk), .reset_n(reset_n), .ins_W(ins_W), .ALUout_W(ALUout_W),
    .RData_W(RData_W), .PC8_W(PC8_W), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .jal_W(jal_W), .RM_extOp(RM_extOp), .A1(A1), .A2(A2),
    .RD1(RD1), .RD2(RD2), .WE_out(WE_out), .WA_out(WA_out), .WD_out(WD_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void model_reset();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
    model[28] = 32'h0000_1800;
    model[29] = 32'h0000_2ffc;
  endfunction

  function automatic logic [4:0] exp_wa();
    if (jal_W) return 5'd31;
    if (RegDst) return ins_W[15:11];
    return ins_W[20:16];
  endfunction

  function automatic logic [31:0] exp_wd();
    int unsigned off;
    int unsigned b;
    int unsigned h;
    off = int'(ALUout_W[1:0]);
    b = (RData_W >> (8 * off)) & 32'hFF;
    h = (RData_W >> (16 * (off / 2))) & 32'hFFFF;
    if (jal_W || (ins_W[31:26] == 6'd0 && ins_W[5:0] == 6'd9)) return PC8_W;
    if (!MemtoReg) return ALUout_W;
    case (RM_extOp)
      3'd1: return b;
      3'd2: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd3: return h;
      3'd4: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      default: return RData_W;
    endcase
  endfunction

  function automatic logic exp_we();
    return RegWrite && (exp_wa() != 5'd0);
  endfunction

  function automatic logic [31:0] exp_rd(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (exp_we() && a == exp_wa()) return exp_wd();
    return model[a];
  endfunction

  task automatic drive(input logic [31:0] ins, input logic [31:0] alu, input logic [31:0] rdata,
                       input logic [31:0] pc8, input logic m2r, input logic rdst,
                       input logic rw, input logic jal, input logic [2:0] ext);
    ins_W = ins; ALUout_W = alu; RData_W = rdata; PC8_W = pc8;
    MemtoReg = m2r; RegDst = rdst; RegWrite = rw; jal_W = jal; RM_extOp = ext;
  endtask

  task automatic idle();
    drive(32'd0, 32'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
  endtask

  // Advance one clock and commit to the model what the edge should have written.
  task automatic step();
    logic we;
    logic [4:0] wa;
    logic [31:0] wd;
    we = exp_we(); wa = exp_wa(); wd = exp_wd();
    @(posedge clk);
    if (reset_n && we) model[wa] = wd;
    #1;
  endtask

  task automatic test_reset();
    idle();
    A1 = 5'd0; A2 = 5'd0;
    reset_n = 1'b1;
    #7 reset_n = 1'b0;
    model_reset();
    #1 A1 = 5'd29; A2 = 5'd28;
    #1;
    vectors++;
    if (RD1 !== 32'h0000_2ffc) begin miscompares++; $display("FAIL reset_sp: got %h want %h", RD1, 32'h0000_2ffc); end
    vectors++;
    if (RD2 !== 32'h0000_1800) begin miscompares++; $display("FAIL reset_gp: got %h want %h", RD2, 32'h0000_1800); end
    A1 = 5'd5;
    #1;
    vectors++;
    if (RD1 !== 32'd0) begin miscompares++; $display("FAIL reset_r5: got %h want 0", RD1); end
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) step();
    A1 = 5'd29; A2 = 5'd28;
    #1;
    vectors++;
    if (RD1 !== 32'h0000_2ffc || RD2 !== 32'h0000_1800) begin
      miscompares++; $display("FAIL reset_hold: got %h/%h want 00002ffc/00001800", RD1, RD2);
    end
  endtask

  task automatic test_alu_write();
    @(negedge clk);
    A1 = 5'd3;
    drive({6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'b100001}, 32'h1234_5678, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
    #1;
    vectors++;
    if (RD1 !== 32'h1234_5678 || WE_out !== 1'b1 || WA_out !== 5'd3) begin
      miscompares++; $display("FAIL addu_bypass: got rd1=%h we=%b wa=%0d want 12345678/1/3", RD1, WE_out, WA_out);
    end
    step();
    idle();
    #1;
    vectors++;
    if (RD1 !== 32'h1234_5678) begin miscompares++; $display("FAIL addu_stored: got %h want 12345678", RD1); end
  endtask

  task automatic test_loads();
    logic [2:0]  ext [4]  = '{3'd2, 3'd1, 3'd4, 3'd3};
    logic [1:0]  off [4]  = '{2'd2, 2'd3, 2'd2, 2'd0};
    logic [31:0] want [4] = '{32'hFFFF_FFFF, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      A1 = 5'(8 + i);
      drive({6'h20, 5'd1, 5'(8 + i), 16'd0}, {30'h400, off[i]}, 32'h80FF_7F01, 32'd0,
            1'b1, 1'b0, 1'b1, 1'b0, ext[i]);
      #1;
      vectors++;
      if (WD_out !== want[i] || RD1 !== want[i]) begin
        miscompares++; $display("FAIL load%0d: got wd=%h rd1=%h want %h", i, WD_out, RD1, want[i]);
      end
      step();
    end
    idle();
    A1 = 5'd10;
    #1;
    vectors++;
    if (RD1 !== 32'hFFFF_80FF) begin miscompares++; $display("FAIL lh_stored: got %h want ffff80ff", RD1); end
  endtask

  task automatic test_jal();
    @(negedge clk);
    A1 = 5'd31;
    drive({6'h03, 26'h0000C02}, 32'h5555_0000, 32'd0, 32'h0000_3008, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0);
    #1;
    vectors++;
    if (WA_out !== 5'd31 || WD_out !== 32'h0000_3008 || RD1 !== 32'h0000_3008) begin
      miscompares++; $display("FAIL jal: got wa=%0d wd=%h rd1=%h want 31/00003008", WA_out, WD_out, RD1);
    end
    step();
    @(negedge clk);
    A1 = 5'd7;
    drive({6'd0, 5'd31, 5'd0, 5'd7, 5'd0, 6'b001001}, 32'hAAAA_AAAA, 32'd0, 32'h0000_3010,
          1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
    step();
    idle();
    #1;
    vectors++;
    if (RD1 !== 32'h0000_3010) begin miscompares++; $display("FAIL jalr: got %h want 00003010", RD1); end
  endtask

  task automatic test_zero_reg();
    @(negedge clk);
    A1 = 5'd0;
    drive({6'd0, 5'd1, 5'd2, 5'd0, 5'd0, 6'b100001}, 32'hDEAD_BEEF, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
    #1;
    vectors++;
    if (WE_out !== 1'b0 || RD1 !== 32'd0) begin
      miscompares++; $display("FAIL zero_pre: got we=%b rd1=%h want 0/0", WE_out, RD1);
    end
    step();
    #1;
    vectors++;
    if (RD1 !== 32'd0) begin miscompares++; $display("FAIL zero_post: got %h want 0", RD1); end
    idle();
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    A2 = 5'd4;
    drive({6'd0, 5'd0, 5'd0, 5'd4, 5'd0, 6'b100001}, 32'd1, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 3'd0);
    #1;
    vectors++;
    if (RD2 !== 32'd1) begin miscompares++; $display("FAIL b2b_first: got %h want 1", RD2); end
    step();
    ALUout_W = 32'd2;
    reset_n = 1'b0;
    model_reset();
    #1;
    vectors++;
    if (RD2 !== 32'd2) begin miscompares++; $display("FAIL b2b_second_bypass: got %h want 2", RD2); end
    step();
    idle();
    #1;
    vectors++;
    if (RD2 !== 32'd0) begin miscompares++; $display("FAIL b2b_reset_lost: got %h want 0", RD2); end
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_random();
    logic [31:0] ins;
    for (int n = 0; n < 300; n++) begin
      @(negedge clk);
      ins = $urandom;
      if ($urandom_range(0, 5) == 0) begin
        ins[31:26] = 6'd0; ins[5:0] = 6'b001001;
      end
      drive(ins, $urandom, $urandom, $urandom, 1'($urandom), 1'($urandom),
            ($urandom_range(0, 3) != 0), ($urandom_range(0, 7) == 0), 3'($urandom));
      A1 = 5'($urandom);
      A2 = ($urandom_range(0, 2) == 0) ? exp_wa() : 5'($urandom);
      #1;
      vectors++;
      if (WE_out !== exp_we() || WA_out !== exp_wa() || WD_out !== exp_wd()) begin
        miscompares++;
        $display("FAIL rand_wr%0d: got we=%b wa=%0d wd=%h want %b/%0d/%h",
                 n, WE_out, WA_out, WD_out, exp_we(), exp_wa(), exp_wd());
      end
      vectors++;
      if (RD1 !== exp_rd(A1) || RD2 !== exp_rd(A2)) begin
        miscompares++;
        $display("FAIL rand_rd%0d: got %h/%h want %h/%h", n, RD1, RD2, exp_rd(A1), exp_rd(A2));
      end
      step();
    end
    idle();
    for (int a = 0; a < 32; a++) begin
      A1 = 5'(a);
      #1;
      vectors++;
      if (RD1 !== exp_rd(A1)) begin
        miscompares++; $display("FAIL final_r%0d: got %h want %h", a, RD1, exp_rd(A1));
      end
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    model_reset();
    test_reset();
    test_alu_write();
    test_loads();
    test_jal();
    test_zero_reg();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
